// File: rtl/alu_branch_sequencer_if.sv
// Bundle between instruction decode / ALU and the branch sequencer.
//   master : decode/top-level side (drives start, stall, decode flags, target, ALU compare result)
//   slave  : alu_branch_sequencer (drives pc, ALU phase markers, busy/done, taken_cnt)
interface alu_branch_sequencer_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             stall;
    logic             dec_beq;
    logic             dec_jmp;
    logic             dec_halt;
    logic [PC_W-1:0]  br_target;
    logic             alu_out_beq;
    logic [PC_W-1:0]  pc;
    logic             alu_in_beq;
    logic             alu_jumped;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output start, stall, dec_beq, dec_jmp, dec_halt, br_target, alu_out_beq,
        input  pc, alu_in_beq, alu_jumped, busy, done, taken_cnt
    );

    modport slave (
        input  start, stall, dec_beq, dec_jmp, dec_halt, br_target, alu_out_beq,
        output pc, alu_in_beq, alu_jumped, busy, done, taken_cnt
    );
endinterface

// File: rtl/alu_branch_sequencer.sv
// Program-counter owner that sequences the ALU two-phase branch protocol
// (compare cycle, then jump cycle) and offers a start/done run handshake.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : alu_branch_sequencer_if.slave
//              in : start, stall, dec_beq, dec_jmp, dec_halt, br_target, alu_out_beq
//              out: pc, alu_in_beq, alu_jumped, busy, done, taken_cnt
//
// Build option: define BRANCH_STATS_EN to implement the taken-branch counter;
// otherwise taken_cnt reads constant zero and the counter register is absent.
// All outputs are registered; no input reaches an output combinationally.
module alu_branch_sequencer #(
    parameter int unsigned PC_W   = 9,
    parameter int unsigned MAX_PC = 511,
    parameter int unsigned CNT_W  = 8
) (
    input logic                   clk,
    input logic                   reset_n,
    alu_branch_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRun, StCmp, StJump, StDone} state_e;

    localparam logic [PC_W-1:0] PcLast = PC_W'(MAX_PC);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] target_q;
    logic            busy_q;
    logic            done_q;
    logic            in_beq_q;
    logic            jumped_q;

    // Output flags {busy, done, alu_in_beq, alu_jumped} for the state being entered,
    // so they are registered alongside the state itself.
    function automatic logic [3:0] flags_for(state_e s);
        unique case (s)
            StRun:   flags_for = 4'b1000;
            StCmp:   flags_for = 4'b1010;
            StJump:  flags_for = 4'b1001;
            StDone:  flags_for = 4'b0100;
            default: flags_for = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q                                 <= StIdle;
            pc_q                                    <= '0;
            target_q                                <= '0;
            {busy_q, done_q, in_beq_q, jumped_q}    <= 4'b0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q                              <= StRun;
                        pc_q                                 <= '0;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StRun);
                    end
                end
                StRun: begin
                    if (bus.stall) begin
                        // frozen
                    end else if (bus.dec_halt) begin
                        state_q                              <= StDone;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StDone);
                    end else if (bus.dec_jmp) begin
                        target_q                             <= bus.br_target;
                        state_q                              <= StJump;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StJump);
                    end else if (bus.dec_beq) begin
                        target_q                             <= bus.br_target;
                        state_q                              <= StCmp;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StCmp);
                    end else if (pc_q != PcLast) begin
                        pc_q <= pc_q + 1'b1;
                    end else begin
                        // Falling off the end of memory ends the run; no wrap.
                        state_q                              <= StDone;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StDone);
                    end
                end
                StCmp: begin
                    // Stall is deliberately ignored so the ALU compare is one cycle.
                    if (bus.alu_out_beq) begin
                        state_q                              <= StJump;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StJump);
                    end else if (pc_q != PcLast) begin
                        pc_q                                 <= pc_q + 1'b1;
                        state_q                              <= StRun;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StRun);
                    end else begin
                        state_q                              <= StDone;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StDone);
                    end
                end
                StJump: begin
                    pc_q                                 <= target_q;
                    state_q                              <= StRun;
                    {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StRun);
                end
                StDone: begin
                    // Hold done until the requester drops start.
                    if (!bus.start) begin
                        state_q                              <= StIdle;
                        {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StIdle);
                    end
                end
                default: begin
                    state_q                              <= StIdle;
                    {busy_q, done_q, in_beq_q, jumped_q} <= flags_for(StIdle);
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q;

    // Cleared at run start; every jump phase (taken beq or jmp) counts, saturating.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taken_cnt_q <= '0;
        end else if (state_q == StIdle && bus.start) begin
            taken_cnt_q <= '0;
        end else if (state_q == StJump && taken_cnt_q != {CNT_W{1'b1}}) begin
            taken_cnt_q <= taken_cnt_q + 1'b1;
        end
    end

    assign bus.taken_cnt = taken_cnt_q;
`else
    assign bus.taken_cnt = {CNT_W{1'b0}};
`endif

    assign bus.pc         = pc_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.alu_in_beq = in_beq_q;
    assign bus.alu_jumped = jumped_q;

endmodule

// File: tb/tb_alu_branch_sequencer.sv
module tb_alu_branch_sequencer;

    localparam int MaxPc  = 511;
    localparam int CntMax = 255;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MCmp  = 2;
    localparam int MJump = 3;
    localparam int MDone = 4;

    typedef struct {
        string      lbl;
        logic [8:0] pc;
        logic       busy;
        logic       done;
        logic       inb;
        logic       jmp;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    alu_branch_sequencer_if #(.PC_W(9), .CNT_W(8)) bus ();

    alu_branch_sequencer #(.PC_W(9), .MAX_PC(511), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: run mode, program counter, remembered target, taken count.
    int m_mode = MIdle;
    int m_pc   = 0;
    int m_tgt  = 0;
    int m_cnt  = 0;

    task automatic model_step();
        if (!reset_n) begin
            m_mode = MIdle; m_pc = 0; m_tgt = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                MIdle: if (bus.start) begin m_mode = MRun; m_pc = 0; m_cnt = 0; end
                MRun: if (!bus.stall) begin
                    if (bus.dec_halt)     m_mode = MDone;
                    else if (bus.dec_jmp) begin m_tgt = int'(bus.br_target); m_mode = MJump; end
                    else if (bus.dec_beq) begin m_tgt = int'(bus.br_target); m_mode = MCmp; end
                    else if (m_pc < MaxPc) m_pc = m_pc + 1;
                    else                  m_mode = MDone;
                end
                MCmp: begin
                    if (bus.alu_out_beq)   m_mode = MJump;
                    else if (m_pc < MaxPc) begin m_pc = m_pc + 1; m_mode = MRun; end
                    else                   m_mode = MDone;
                end
                MJump: begin
                    m_pc = m_tgt;
                    if (m_cnt < CntMax) m_cnt = m_cnt + 1;
                    m_mode = MRun;
                end
                default: if (!bus.start) m_mode = MIdle;
            endcase
        end
    endtask

    // Apply current inputs for one clock: predict, queue expectation, advance.
    task automatic cyc(input string lbl);
        exp_t e;
        model_step();
        e.lbl  = lbl;
        e.pc   = 9'(m_pc);
        e.busy = (m_mode == MRun || m_mode == MCmp || m_mode == MJump);
        e.done = (m_mode == MDone);
        e.inb  = (m_mode == MCmp);
        e.jmp  = (m_mode == MJump);
`ifdef BRANCH_STATS_EN
        e.cnt  = 8'(m_cnt);
`else
        e.cnt  = 8'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic st, input logic stl, input logic beq, input logic jmp,
                         input logic hlt, input int tgt, input logic eq);
        bus.start       = st;
        bus.stall       = stl;
        bus.dec_beq     = beq;
        bus.dec_jmp     = jmp;
        bus.dec_halt    = hlt;
        bus.br_target   = 9'(tgt);
        bus.alu_out_beq = eq;
    endtask

    // Monitor: every cycle the DUT presents a registered output set; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus.pc !== e.pc || bus.busy !== e.busy || bus.done !== e.done ||
                    bus.alu_in_beq !== e.inb || bus.alu_jumped !== e.jmp ||
                    bus.taken_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: got pc=%0d busy=%b done=%b in_beq=%b jumped=%b cnt=%0d want pc=%0d busy=%b done=%b in_beq=%b jumped=%b cnt=%0d",
                             e.lbl, bus.pc, bus.busy, bus.done, bus.alu_in_beq,
                             bus.alu_jumped, bus.taken_cnt, e.pc, e.busy, e.done, e.inb,
                             e.jmp, e.cnt);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset held with start high.
        repeat (2) cyc("reset");
        reset_n = 1'b1;
        cyc("start");
        repeat (5) cyc("seq");                          // pc 0 -> 5

        // Taken beq at pc=5 to 40; decode noise during CMP/JUMP must be ignored.
        drive(1, 0, 1, 0, 0, 40, 0); cyc("beq_issue");
        drive(1, 1, 0, 1, 1, 99, 1); cyc("beq_cmp_taken");
        drive(1, 1, 1, 1, 0, 77, 0); cyc("beq_jump");
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("after_jump");

        // Jump back to 5, then not-taken beq.
        drive(1, 0, 0, 1, 0, 5, 0);  cyc("jmp_issue");
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("jmp_jump");
        drive(1, 0, 1, 0, 0, 123, 0); cyc("nt_issue");
        drive(1, 1, 0, 0, 0, 0, 0);  cyc("nt_cmp");      // stall ignored in CMP
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("nt_after");

        // Stall freezes everything, even with decode flags up.
        drive(1, 1, 1, 1, 0, 300, 1);
        repeat (4) cyc("stall");
        // halt beats jmp
        drive(1, 0, 0, 1, 1, 300, 0); cyc("halt_prio");
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc("done_hold");
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("to_idle");
        cyc("idle");

        // Sequential run to the last address: no wrap.
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("start2");
        drive(1, 0, 0, 1, 0, 500, 0); cyc("jmp500");
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("jmp500_j");
        repeat (13) cyc("seq_end");
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("to_idle2");

        // Not-taken beq at the last address ends the run.
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("start3");
        drive(1, 0, 0, 1, 0, 511, 0); cyc("jmp511");
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("jmp511_j");
        drive(1, 0, 1, 0, 0, 3, 0);  cyc("beq511");
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("beq511_cmp");
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("to_idle3");

        // 300 self-loop jumps: counter saturates.
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("start4");
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 0, 1, 0, m_pc, 0); cyc("selfloop");
            drive(1, 0, 0, 0, 0, 0, 0);    cyc("selfloop_j");
        end
        cyc("sat_seq");

        // Reset during CMP.
        drive(1, 0, 1, 0, 0, 77, 1); cyc("beq_pre_rst");
        reset_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 1);  cyc("rst_in_cmp");
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 29) == 0), int'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) bus.br_target = 9'(m_pc);
            cyc("random");
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_branch_sequencer.md
Name: alu_branch_sequencer

Overview:
- Clocked controller that owns the program counter and sequences the ALU's two-phase branch protocol: a compare cycle (drives ALU in_beq, samples out_beq), then a jump cycle (drives ALU jumped, loads the target).
- Sits between instruction decode and the combinational ALU.
- Gives top level a start/done handshake for one program run.

Parameters:
- PC_W, 9, program counter width; matches the ALU 9-bit branch target.
- MAX_PC, 511, last legal instruction address; sequential fall-through past it ends the run.
- CNT_W, 8, width of the taken-branch counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  level request to begin a run from address 0.
- stall  input  1  freeze the sequencer for this cycle.
- dec_beq  input  1  current instruction is a conditional beq.
- dec_jmp  input  1  current instruction is an unconditional absolute jump.
- dec_halt  input  1  current instruction is halt.
- br_target  input  PC_W  branch/jump target from decode.
- alu_out_beq  input  1  ALU compare result (1 = operands equal).
- pc  output  PC_W  current instruction address.
- alu_in_beq  output  1  ALU compare-phase enable.
- alu_jumped  output  1  ALU jump-phase marker; suppresses the ALU jump message and result.
- busy  output  1  run in progress.
- done  output  1  run complete.
- taken_cnt  output  CNT_W  count of taken branches and jumps in the current run.

Behaviour:
- Reset (reset_n=0 at an edge), any state, including mid-branch:
  - state=IDLE, pc=0, taken_cnt=0, latched target=0.
  - All 1-bit outputs 0.
- States: IDLE, RUN, CMP, JUMP, DONE. Output decode is registered from state:
  - busy=1 in RUN/CMP/JUMP.
  - done=1 only in DONE.
  - alu_in_beq=1 only in CMP.
  - alu_jumped=1 only in JUMP.
- IDLE: start=1 -> RUN, pc=0, taken_cnt=0.
- RUN, one decision per cycle, priority halt > jmp > beq > sequential:
  - stall=1: hold everything.
  - dec_halt: -> DONE, pc held.
  - dec_jmp: latch br_target -> JUMP.
  - dec_beq: latch br_target -> CMP, pc held.
  - Otherwise, pc<MAX_PC: pc=pc+1.
  - Otherwise, pc==MAX_PC: -> DONE, pc held. No wrap to 0.
- CMP: exactly one cycle, alu_in_beq=1. stall is ignored so the ALU compare is never stretched.
  - alu_out_beq=1: -> JUMP.
  - alu_out_beq=0: pc=pc+1 (or DONE if pc==MAX_PC), -> RUN.
- JUMP: exactly one cycle, alu_jumped=1.
  - pc=latched target.
  - taken_cnt+1, saturating at all-ones.
  - -> RUN.
  - A target equal to the current pc is legal (self-loop); each pass counts.
- DONE: done held at 1 while start=1. start=0 -> IDLE.
  - start must drop before a new run begins; done never pulses for only one cycle unless start has already dropped.
- Latency:
  - Taken beq: 3 cycles (RUN, CMP, JUMP); pc equals target on the cycle after JUMP.
  - Not-taken beq: 2 cycles.
  - dec_jmp: 2 cycles.
  - Sequential instruction: 1 cycle.
- Decode inputs are sampled only in RUN and ignored in every other state.
- Multiple decode flags high at once resolve by the priority above.
- No combinational path from any input to any output.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined: taken_cnt is implemented as specified.
- When undefined: taken_cnt is tied to 0, the counter register is removed, and all other behaviour is identical.

Test Plan:
- Reset and start: hold reset_n=0 for 2 cycles with start=1 -> pc=0, busy=0, done=0. Release -> next edge busy=1, pc=0; after 3 idle instructions pc=3.
- Taken beq: at pc=5, dec_beq=1, br_target=40, alu_out_beq=1 -> alu_in_beq=1 for 1 cycle, then alu_jumped=1 for 1 cycle, then pc=40; taken_cnt=1 (macro on) or 0 (macro off).
- Not-taken beq: at pc=5, dec_beq=1, alu_out_beq=0 -> alu_in_beq for 1 cycle, alu_jumped never 1, pc=6, taken_cnt unchanged.
- Stall and priority: in RUN with stall=1 for 4 cycles -> pc frozen. Then dec_halt=1 with dec_jmp=1 -> DONE, pc unchanged, done=1 until start=0, then IDLE.
- Boundary: run to pc=511 with no branch -> DONE, pc=511 (no wrap). Issue 300 self-loop jumps -> taken_cnt saturates at 255.
- Reset mid-branch: assert reset_n=0 during CMP -> next edge IDLE, alu_in_beq=0, pc=0, taken_cnt=0.
